mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the MIPS execute stage, implementing MULT, MULTU, DIV and DIVU into architectural HI/LO registers. It feeds the team's `n_adder` block with one add or subtract per cycle, either shift-add or restoring divide, instead of using a wide combinational multiplier. The block sits beside the ALU. The pipeline control stalls MFHI/MFLO while `busy` is high.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- clk  in  1  single clock; all state changes on its rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  launch an operation; sampled only when `busy`=0.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- a  in  WIDTH  rs operand / dividend; sampled with `start`.
- b  in  WIDTH  rt operand / divisor; sampled with `start`.
- abort  in  1  pipeline flush; cancels an in-flight operation.
- hi_we, lo_we  in  1  MTHI/MTLO write enables.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO take a result.
- hi, lo  out  WIDTH  architectural HI and LO registers.

## Operation
- States:
  - IDLE: accepts `start`.
  - CALC: counter 0..WIDTH-1, one iteration per cycle.
  - FIX: sign correction and HI/LO write.
  - FIX always returns to IDLE.
- Start accept (IDLE, `start`=1):
  - Latch `op`.
  - Latch operand magnitudes: two's-complement absolute value for MULT/DIV, raw for MULTU/DIVU.
  - Latch the result sign bits.
  - Clear the counter. Go to CALC.
- Multiply iteration:
  - 2·WIDTH-bit accumulator {P, Q}, Q initialised to |a|, P to 0.
  - If Q[0]=1, P ← P + |b| via the adder, capturing carry-out.
  - Then shift {carry, P, Q} right by one.
- Divide iteration (restoring):
  - Remainder R (WIDTH+1 bits), quotient Q initialised to |a|.
  - Shift {R, Q} left by one.
  - Trial R − |b| via the adder: invert |b|, c_in=1.
  - If non-negative, keep the difference and set Q[0]=1; else restore R.
- FIX:
  - MULT with differing operand signs: negate the 2·WIDTH product. Then hi ← P, lo ← Q.
  - DIV: quotient negated if sign(a)≠sign(b); remainder takes the sign of a. Then lo ← quotient, hi ← remainder.
- Divide by zero (DIV and DIVU): lo ← all ones, hi ← a as sampled; no sign correction. Full latency still applies.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF (WIDTH=32) gives lo=0x80000000, hi=0. This falls out of the magnitude algorithm.
- `start` while `busy`=1 is ignored; no queueing.
- `abort` while busy: return to IDLE next edge, HI/LO unchanged, no `done`. `abort` in IDLE has no effect. If `abort` and `start` are both high in IDLE, `start` wins.
- MTHI/MTLO: `hi_we`/`lo_we` write `wdata` only when `busy`=0.
  - Ignored while busy.
  - If in the same cycle as an accepted start, the write takes effect and is later overwritten by the result.
  - In the cycle where `done` is high, `busy`=0, so writes are accepted.

## Timing
- Reset (async, n_rst=0): state IDLE, hi=0, lo=0, busy=0, done=0, counter 0.
- Reset mid-operation: the operation is discarded immediately; same values as above.
- Start sampled at edge E0:
  - `busy`=1 after E0.
  - Iterations occur on edges E1..EWIDTH.
  - FIX occurs at edge E(WIDTH+1): hi/lo update, `done`=1 for one cycle, `busy`=0.
- Latency: start edge to `done` edge is WIDTH+1 cycles (33 for WIDTH=32), for all ops.
- Back-to-back: a new `start` in the `done` cycle is accepted. Throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are never high together.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, WIDTH=32 -> `done` 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (−3) × 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9 (−7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, same 33-cycle latency.
- Start MULTU 3×4; `start` DIVU 9/3 at cycle 5 -> ignored, hi=0, lo=12. Then `hi_we`, `wdata`=0xAAAA_5555 while busy -> ignored; in IDLE -> hi=0xAAAA5555.
- Start DIVU, `abort` at iteration 10 -> IDLE next edge, no `done`, HI/LO unchanged. Separately, `n_rst` low mid-MULT -> busy=0, hi=lo=0 immediately. A following start completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Handshake and HI/LO bus between the execute-stage control and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per cycle,
// sign fix-up in a final cycle, results held in the architectural HI/LO registers.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           n_rst,
  mult_div_unit_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             div_q;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] mag_b;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Operand conditioning at start. A divide by zero keeps a raw so the remainder
  // naturally ends up as a, and suppresses any sign correction.
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;

  always_comb begin
    a_neg    = bus.a[WIDTH-1] & ~bus.op[0];
    b_neg    = bus.b[WIDTH-1] & ~bus.op[0];
    div_zero = bus.op[1] & (bus.b == '0);
    mag_a_c  = (a_neg & ~div_zero) ? -bus.a : bus.a;
    mag_b_c  = b_neg ? -bus.b : bus.b;
  end

  // Shared adder: P + |b| for multiply, shifted R - |b| for divide.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] add_x;
  logic [WIDTH:0] add_y;
  logic           add_cin;
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] p_next;

  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    add_x   = {1'b0, rem};
    add_y   = {1'b0, mag_b};
    add_cin = 1'b0;
    if (div_q) begin
      add_x   = rem_sh;
      add_y   = ~{1'b0, mag_b};
      add_cin = 1'b1;
    end
    add_sum = add_x + add_y + SUM_W'(add_cin);
    p_next  = quo[0] ? add_sum : {1'b0, rem};
  end

  // Final sign correction for both product and quotient/remainder.
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod     = {rem, quo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -quo : quo;
    rem_fix  = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      mag_b  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            state  <= CALC;
            busy_q <= 1'b1;
            cnt    <= '0;
            div_q  <= bus.op[1];
            neg_q  <= (a_neg ^ b_neg) & ~div_zero;
            neg_r  <= a_neg & ~div_zero;
            rem    <= '0;
            quo    <= mag_a_c;
            mag_b  <= mag_b_c;
          end
        end
        CALC: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            if (div_q) begin
              // Restoring step: a clear sign bit means the trial subtraction fit.
              if (!add_sum[WIDTH]) begin
                rem <= add_sum[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
              end else begin
                rem <= rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
              end
            end else begin
              rem <= p_next[WIDTH:1];
              quo <= {p_next[0], quo[WIDTH-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!bus.abort) begin
            done_q <= 1'b1;
            if (div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at launch, compared on done.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  int   cyc;
  int   start_cyc;
  res_t sb[$];
  res_t pend;
  logic [W-1:0] arch_hi;
  logic [W-1:0] arch_lo;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: returns {hi, lo} for an op.
  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0]        p;
    logic signed [W-1:0] sq;
    logic signed [W-1:0] sr;
    res_t r;
    case (op)
      2'd0: begin
        p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        r = {p[63:32], p[31:0]};
      end
      2'd1: begin
        p = {32'b0, a} * {32'b0, b};
        r = {p[63:32], p[31:0]};
      end
      2'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          r = {sr, sq};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic expect_res(input logic [W-1:0] h, input logic [W-1:0] l);
    pend = {h, l};
    sb.push_back(pend);
  endtask

  // Drives a start now (caller is away from the clock edge); returns #1 after the accepting edge.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc - start_cyc), 64'd33);
    arch_hi = pend.hi;
    arch_lo = pend.lo;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    r = model(op, a, b);
    expect_res(r.hi, r.lo);
    launch(op, a, b);
    wait_done();
  endtask

  // Scoreboard consumer: every done pops one expectation.
  always @(negedge clk) begin
    if (n_rst && bus.done) begin
      check("busy_done_excl", 64'(bus.busy), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("hi", 64'(bus.hi), 64'(e.hi));
        check("lo", 64'(bus.lo), 64'(e.lo));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; start_cyc = 0;
    arch_hi = '0; arch_lo = '0; pend = '0;
    n_rst = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    bus.abort = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    #2;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases with hand-computed results, issued back to back.
    expect_res(32'hFFFF_FFFE, 32'h0000_0001); launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFEB); launch(2'd0, 32'hFFFF_FFFD, 32'h0000_0007); wait_done();
    expect_res(32'h4000_0000, 32'h0000_0000); launch(2'd0, 32'h8000_0000, 32'h8000_0000); wait_done();
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD); launch(2'd2, 32'hFFFF_FFF9, 32'h0000_0002); wait_done();
    expect_res(32'h0000_0001, 32'h0000_0003); launch(2'd3, 32'h0000_0007, 32'h0000_0002); wait_done();
    expect_res(32'h0000_0000, 32'h8000_0000); launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    expect_res(32'h0000_0005, 32'hFFFF_FFFF); launch(2'd3, 32'h0000_0005, 32'h0000_0000); wait_done();

    // MTLO in the done cycle is accepted.
    bus.lo_we = 1'b1; bus.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    arch_lo = 32'h1234_5678;
    check("mtlo_done_cycle", 64'(bus.lo), 64'(arch_lo));

    // start and MTHI while busy are ignored.
    expect_res(32'h0, 32'd12); launch(2'd1, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd9; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b1; bus.wdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi_busy_ignored", 64'(bus.hi), 64'(arch_hi));
    wait_done();
    repeat (40) @(posedge clk);
    #1;
    bus.hi_we = 1'b1; bus.wdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    arch_hi = 32'hAAAA_5555;
    check("mthi_idle", 64'(bus.hi), 64'(arch_hi));

    // Abort at iteration 10: back to IDLE, HI/LO held, no done.
    launch(2'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'(arch_hi));
    check("abort_lo", 64'(bus.lo), 64'(arch_lo));
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done_hi", 64'(bus.hi), 64'(arch_hi));

    // Abort together with start in IDLE: start wins.
    expect_res(32'd2, 32'd14);
    bus.abort = 1'b1;
    launch(2'd3, 32'd100, 32'd7);
    bus.abort = 1'b0;
    wait_done();

    // Asynchronous reset mid-MULT.
    launch(2'd0, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_lo", 64'(bus.lo), 64'd0);
    arch_hi = '0; arch_lo = '0;
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    run_op(2'd0, 32'd5, 32'hFFFF_FFFA);

    // Randomised mix against the reference model, including zero divisors.
    for (int i = 0; i < 10; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op(rop, ra, rb);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
